dither_gen: RTL

- Multi-channel dither noise source for the DAC datapath.
- Each channel owns two 32-bit Galois LFSRs.
- On each sample strobe, every channel produces one signed OUT_BITS-wide dither word, shaped per a runtime mode: off, RPDF, TPDF or high-pass TPDF.
- Sits between the sample-rate strobe generator and the requantiser/noise-shaper; per-channel seeds are runtime-reloadable.

---
 rtl/dither_if.sv | 24 ++
 rtl/dither_gen.sv | 107 ++++++++++
 2 files changed

// File: rtl/dither_if.sv
// Sample-strobe, mode and seed-reload bundle for the dither source, plus its
// packed per-channel dither words and valid pulse.
interface dither_if #(
  parameter int CHANNELS = 2,
  parameter int OUT_BITS = 8
);
  logic                         stb;
  logic [1:0]                   mode;
  logic                         seed_wr;
  logic [4:0]                   seed_ch;
  logic [31:0]                  seed_data;
  logic [CHANNELS*OUT_BITS-1:0] dither_out;
  logic                         dither_valid;

  modport master (
    output stb, mode, seed_wr, seed_ch, seed_data,
    input  dither_out, dither_valid
  );

  modport slave (
    input  stb, mode, seed_wr, seed_ch, seed_data,
    output dither_out, dither_valid
  );
endinterface

// File: rtl/dither_gen.sv
// Multi-channel dither source: two 32-bit Galois LFSRs per channel, shaped into
// off / RPDF / TPDF / high-pass TPDF words with a two-edge strobe-to-valid latency.
module dither_gen #(
  parameter int          CHANNELS = 2,
  parameter int          OUT_BITS = 8,
  parameter logic [31:0] SEED     = 32'h9ACF46DE
) (
  input logic     clk,
  input logic     rst,
  dither_if.slave dif
);

  localparam logic [31:0] POLY   = 32'h80200003;
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // Zero is the LFSR lock-up state, so both derivations substitute 1 for it.
  function automatic logic [31:0] seed_a(input logic [31:0] v);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  function automatic logic [31:0] seed_b(input logic [31:0] v);
    logic [31:0] t;
    t = {v[15:0], v[31:16]} ^ 32'h5A5A5A5A;
    return (t == 32'h0) ? 32'h1 : t;
  endfunction

  // Sums and differences are formed one bit wider and halved, so no saturation is needed.
  function automatic logic signed [OUT_BITS-1:0] shape(
    input logic [1:0]                 m,
    input logic signed [OUT_BITS-1:0] sa,
    input logic signed [OUT_BITS-1:0] sb,
    input logic signed [OUT_BITS-1:0] pv
  );
    logic signed [OUT_BITS:0]   ea, eb, ep, acc;
    logic signed [OUT_BITS-1:0] res;
    ea  = {sa[OUT_BITS-1], sa};
    eb  = {sb[OUT_BITS-1], sb};
    ep  = {pv[OUT_BITS-1], pv};
    acc = '0;
    res = '0;
    case (m)
      2'd1:    res = sa;
      2'd2: begin
        acc = ea + eb;
        res = acc[OUT_BITS:1];
      end
      2'd3: begin
        acc = ea - ep;
        res = acc[OUT_BITS:1];
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [31:0]                  st_a [CHANNELS];
  logic [31:0]                  st_b [CHANNELS];
  logic signed [OUT_BITS-1:0]   prev [CHANNELS];
  logic [1:0]                   mode_p0;
  logic                         vld_p0;
  logic                         vld_p1;
  logic [CHANNELS*OUT_BITS-1:0] out_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      mode_p0 <= 2'd0;
      out_p1  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        st_a[c] <= seed_a(SEED ^ (32'(c) * GOLDEN));
        st_b[c] <= seed_b(SEED ^ (32'(c) * GOLDEN));
        prev[c] <= '0;
      end
    end else begin
      // Stage p0: advance generators and latch mode on the strobe.
      vld_p0 <= dif.stb;
      if (dif.stb) mode_p0 <= dif.mode;
      // Stage p1: shape the post-advance states into the output register.
      vld_p1 <= vld_p0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (vld_p0) begin
          out_p1[c*OUT_BITS +: OUT_BITS] <= shape(mode_p0, st_a[c][OUT_BITS-1:0],
                                                  st_b[c][OUT_BITS-1:0], prev[c]);
          prev[c] <= st_a[c][OUT_BITS-1:0];
        end
        // A reload takes precedence over both advancing and the prev update.
        if (dif.seed_wr && (32'(dif.seed_ch) == 32'(c))) begin
          st_a[c] <= seed_a(dif.seed_data);
          st_b[c] <= seed_b(dif.seed_data);
          prev[c] <= '0;
        end else if (dif.stb) begin
          st_a[c] <= lfsr_step(st_a[c]);
          st_b[c] <= lfsr_step(st_b[c]);
        end
      end
    end
  end

  assign dif.dither_out   = out_p1;
  assign dif.dither_valid = vld_p1;

endmodule
